// File: rtl/bpg_pkg.sv
// Shared types and defaults for the BPG pattern sequencer and its pattern RAM wrapper.
package bpg_pkg;

    localparam int BPG_DATA_W = 16;
    localparam int BPG_ADDR_W = 12;
    localparam int BPG_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } bpg_state_e;

    // One pattern-memory entry: the word driven on the pins and how long it is held.
    typedef struct packed {
        logic [BPG_DATA_W-1:0] data;
        logic [BPG_CNT_W-1:0]  len;
    } bpg_entry_t;

endpackage

// File: rtl/bpg_hold_counter.sv
// Per-word hold counter: loads max(len,1), counts down, flags the last cycle of the hold.
module bpg_hold_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (len_i == '0) ? CNT_W'(1) : len_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/bpg_pattern_sequencer.sv
// Plays pattern-memory words on the BPG pins, each for its hold length, gap-free,
// in single-shot or looping mode, with a one-entry prefetch buffer behind the output.
module bpg_pattern_sequencer
    import bpg_pkg::*;
#(
    parameter int DATA_W = BPG_DATA_W,
    parameter int ADDR_W = BPG_ADDR_W,
    parameter int CNT_W  = BPG_CNT_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_loop,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [CNT_W-1:0]  mem_len,
    output logic [DATA_W-1:0] pattern_out,
    output logic              pattern_valid,
    output logic              busy,
    output logic              done
);

    bpg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              loop_q, loop_d;
    logic              stop_q, stop_d;
    logic              fetch_done_q, fetch_done_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [CNT_W-1:0]  buf_len_q, buf_len_d;
    logic              buf_last_q, buf_last_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              out_last_q, out_last_d;

    logic              active;
    logic              hold_last;
    logic              ending;
    logic              consume;
    logic              slot_free;
    logic              rd;
    logic [DATA_W-1:0] src_data;
    logic [CNT_W-1:0]  src_len;
    logic              src_last;

    bpg_hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold (
        .clk_i  (clk_in),
        .rst_ni (reset),
        .load_i (consume),
        .len_i  (src_len),
        .last_o (hold_last)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        end_d        = end_q;
        loop_d       = loop_q;
        stop_d       = stop_q;
        fetch_done_d = fetch_done_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_len_d    = buf_len_q;
        buf_last_d   = buf_last_q;
        out_d        = out_q;
        valid_d      = valid_q;
        out_last_d   = out_last_q;

        active   = (state_q == PRIME) || (state_q == RUN);
        src_data = buf_valid_q ? buf_data_q : mem_data;
        src_len  = buf_valid_q ? buf_len_q  : mem_len;
        src_last = buf_valid_q ? buf_last_q : pend_last_q;

        // Playback ends at a hold boundary on a recorded stop or after the last word in single shot.
        ending    = (state_q == RUN) && hold_last && (stop_q || (out_last_q && !loop_q));
        consume   = ((state_q == PRIME) && pend_q) || ((state_q == RUN) && hold_last && !ending);
        // A new read is allowed only if its data is guaranteed a home one cycle later.
        slot_free = (!buf_valid_q && !pend_q) || (consume && !(buf_valid_q && pend_q));
        rd        = active && !fetch_done_q && slot_free && !ending;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = PRIME;
                    addr_d       = '0;
                    end_d        = end_addr;
                    loop_d       = mode_loop;
                    stop_d       = 1'b0;
                    fetch_done_d = 1'b0;
                    buf_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                end
            end
            PRIME, RUN: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (consume) begin
                    out_d      = src_data;
                    valid_d    = 1'b1;
                    out_last_d = src_last;
                    if (buf_valid_q) begin
                        buf_valid_d = pend_q;
                        buf_data_d  = mem_data;
                        buf_len_d   = mem_len;
                        buf_last_d  = pend_last_q;
                    end
                    if (state_q == PRIME) begin
                        state_d = RUN;
                    end
                end else if (pend_q) begin
                    buf_valid_d = 1'b1;
                    buf_data_d  = mem_data;
                    buf_len_d   = mem_len;
                    buf_last_d  = pend_last_q;
                end
                if (ending) begin
                    state_d     = FLUSH;
                    out_d       = '0;
                    valid_d     = 1'b0;
                    out_last_d  = 1'b0;
                    buf_valid_d = 1'b0;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd) begin
            pend_d      = 1'b1;
            pend_last_d = (addr_q == end_q);
            addr_d      = (addr_q == end_q) ? '0 : addr_q + ADDR_W'(1);
            if ((addr_q == end_q) && !loop_q) begin
                fetch_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            end_q        <= '0;
            loop_q       <= 1'b0;
            stop_q       <= 1'b0;
            fetch_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            buf_len_q    <= '0;
            buf_last_q   <= 1'b0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            end_q        <= end_d;
            loop_q       <= loop_d;
            stop_q       <= stop_d;
            fetch_done_q <= fetch_done_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            buf_len_q    <= buf_len_d;
            buf_last_q   <= buf_last_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_rd        = rd;
    assign pattern_out   = out_q;
    assign pattern_valid = valid_q;
    assign busy          = active;
    assign done          = (state_q == FLUSH);

endmodule

// File: tb/tb_bpg_pattern_sequencer.sv
// Directed bench for bpg_pattern_sequencer with a synchronous-read pattern memory model.
module tb_bpg_pattern_sequencer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode_loop;
    logic [11:0] end_addr;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] mem_len;
    logic [15:0] pattern_out;
    logic        pattern_valid;
    logic        busy;
    logic        done;

    logic [15:0] mem_d [4096];
    logic [15:0] mem_l [4096];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ss_pat [7] = '{16'hA1, 16'hA1, 16'hA1, 16'hB2, 16'hC3, 16'hC3, 16'h0};

    bpg_pattern_sequencer dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .mode_loop     (mode_loop),
        .end_addr      (end_addr),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_len       (mem_len),
        .pattern_out   (pattern_out),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (mem_rd) begin
            mem_data <= mem_d[mem_addr];
            mem_len  <= mem_l[mem_addr];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic load(input int a, input logic [15:0] d, input logic [15:0] l);
        mem_d[a] = d;
        mem_l[a] = l;
    endtask

    task automatic start_run(input logic [11:0] ea, input logic lp);
        end_addr  = ea;
        mode_loop = lp;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_d[i] = '0;
            mem_l[i] = '0;
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0; end_addr = '0;
        mem_data = '0; mem_len = '0;
        step(2);
        check_value("rst_pattern", 32'(pattern_out), 32'h0);
        check_value("rst_valid",   32'(pattern_valid), 32'd0);
        check_value("rst_busy",    32'(busy), 32'd0);
        check_value("rst_done",    32'(done), 32'd0);
        check_value("rst_mem_rd",  32'(mem_rd), 32'd0);
        reset = 1'b1;
        step(1);

        // Single shot, lens {3,1,2}
        load(0, 16'hA1, 16'd3); load(1, 16'hB2, 16'd1); load(2, 16'hC3, 16'd2);
        start_run(12'd2, 1'b0);
        check_value("ss_busy_k",  32'(busy), 32'd1);
        check_value("ss_rd_k",    32'(mem_rd), 32'd1);
        check_value("ss_addr_k",  32'(mem_addr), 32'd0);
        check_value("ss_valid_k", 32'(pattern_valid), 32'd0);
        step(1);
        check_value("ss_addr_k1", 32'(mem_addr), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check_value("ss_pattern", 32'(pattern_out), 32'(ss_pat[i]));
            check_value("ss_valid",   32'(pattern_valid), (i < 6) ? 32'd1 : 32'd0);
            check_value("ss_done",    32'(done), (i == 6) ? 32'd1 : 32'd0);
            check_value("ss_busy",    32'(busy), (i < 6) ? 32'd1 : 32'd0);
        end
        step(1);
        check_value("ss_done_end", 32'(done), 32'd0);

        // Reset while word 3 plays
        for (int i = 0; i < 6; i++) load(i, 16'hD0 + 16'(i), 16'd2);
        start_run(12'd5, 1'b0);
        step(8);
        check_value("mr_word3", 32'(pattern_out), 32'hD3);
        reset = 1'b0;
        #1;
        check_value("mr_pattern", 32'(pattern_out), 32'h0);
        check_value("mr_valid",   32'(pattern_valid), 32'd0);
        check_value("mr_busy",    32'(busy), 32'd0);
        check_value("mr_rd",      32'(mem_rd), 32'd0);
        check_value("mr_addr",    32'(mem_addr), 32'd0);
        step(1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_value("mr_no_done", 32'(done), 32'd0);
            step(1);
        end
        start_run(12'd5, 1'b0);
        step(2);
        check_value("mr_restart_w0", 32'(pattern_out), 32'hD0);
        check_value("mr_restart_v",  32'(pattern_valid), 32'd1);
        do_reset();

        // Loop, len=1 words, then stop on a boundary edge
        load(0, 16'h55, 16'd1); load(1, 16'hAA, 16'd1);
        start_run(12'd1, 1'b1);
        step(2);
        for (int i = 0; i < 20; i++) begin
            check_value("lp_pattern", 32'(pattern_out), (i % 2 == 0) ? 32'h55 : 32'hAA);
            check_value("lp_valid",   32'(pattern_valid), 32'd1);
            if (i < 19) step(1);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_value("lp_stop_last", 32'(pattern_out), 32'h55);
        check_value("lp_stop_busy", 32'(busy), 32'd1);
        step(1);
        check_value("lp_flush_done",  32'(done), 32'd1);
        check_value("lp_flush_valid", 32'(pattern_valid), 32'd0);
        check_value("lp_flush_pat",   32'(pattern_out), 32'h0);
        check_value("lp_flush_busy",  32'(busy), 32'd0);
        step(1);
        check_value("lp_done_pulse", 32'(done), 32'd0);

        // Zero length clamps to one cycle
        load(0, 16'h11, 16'd0); load(1, 16'h22, 16'd2);
        start_run(12'd1, 1'b0);
        step(2);
        check_value("z_w0", 32'(pattern_out), 32'h11);
        step(1);
        check_value("z_w1a", 32'(pattern_out), 32'h22);
        step(1);
        check_value("z_w1b", 32'(pattern_out), 32'h22);
        step(1);
        check_value("z_done", 32'(done), 32'd1);
        step(1);

        // end_addr=0 looping: single word repeated, address pinned at 0
        load(0, 16'h77, 16'd1);
        start_run(12'd0, 1'b1);
        step(1);
        check_value("e0_addr_k1", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_value("e0_pattern", 32'(pattern_out), 32'h77);
            check_value("e0_addr",    32'(mem_addr), 32'd0);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_value("e0_stop_valid", 32'(pattern_valid), 32'd1);
        step(1);
        check_value("e0_done", 32'(done), 32'd1);
        step(1);

        // Start while busy (with changed end_addr/mode_loop) is ignored
        load(0, 16'h31, 16'd3); load(1, 16'h32, 16'd3);
        start_run(12'd1, 1'b0);
        step(2);
        start = 1'b1; end_addr = 12'd0; mode_loop = 1'b1;
        step(1);
        start = 1'b0;
        check_value("sb_pattern_k3", 32'(pattern_out), 32'h31);
        step(2);
        check_value("sb_pattern_k5", 32'(pattern_out), 32'h32);
        step(3);
        check_value("sb_done_k8", 32'(done), 32'd1);
        step(1);

        // start+stop together in IDLE: run starts, stop discarded
        load(0, 16'h41, 16'd2);
        end_addr = 12'd0; mode_loop = 1'b1; start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check_value("ss2_busy", 32'(busy), 32'd1);
        step(2);
        check_value("ss2_w0", 32'(pattern_out), 32'h41);
        step(2);
        check_value("ss2_still_valid", 32'(pattern_valid), 32'd1);
        check_value("ss2_no_done",     32'(done), 32'd0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check_value("ss2_done", 32'(done), 32'd1);
        step(1);

        // Stop sampled on a boundary edge ends one word later
        load(0, 16'h61, 16'd2); load(1, 16'h62, 16'd2); load(2, 16'h63, 16'd2);
        start_run(12'd2, 1'b1);
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_value("sbd_w1_k4", 32'(pattern_out), 32'h62);
        step(1);
        check_value("sbd_w1_k5", 32'(pattern_out), 32'h62);
        check_value("sbd_busy",  32'(busy), 32'd1);
        step(1);
        check_value("sbd_done",  32'(done), 32'd1);
        check_value("sbd_valid", 32'(pattern_valid), 32'd0);
        step(1);

        // Maximum hold length
        load(0, 16'hE1, 16'hFFFF); load(1, 16'hE2, 16'd1);
        start_run(12'd1, 1'b0);
        step(2);
        check_value("max_first", 32'(pattern_out), 32'hE1);
        step(65534);
        check_value("max_last", 32'(pattern_out), 32'hE1);
        step(1);
        check_value("max_next", 32'(pattern_out), 32'hE2);
        step(1);
        check_value("max_done", 32'(done), 32'd1);
        step(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
